// File: rtl/uart_hex_tx.sv
// uart_hex_tx: accepts a 16-bit word over valid/ready and sends it as four
// uppercase ASCII hex characters (MS nibble first), each an 8N1 frame, LSB
// first, with no gap between characters. tx is driven straight from a flop.
module uart_hex_tx #(
  parameter int unsigned CLK_HZ       = 100000000,
  parameter int unsigned BAUD         = 115200,
  parameter int unsigned CLKS_PER_BIT = CLK_HZ / BAUD
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic        tx,
  output logic        busy
);

  localparam int unsigned CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t        state, state_n;
  logic [CW-1:0] baud, baud_n;
  logic [2:0]    bit_idx, bit_n;
  logic [1:0]    char_idx, char_n;
  logic [15:0]   shadow, shadow_n;
  logic          tx_n;
  logic          baud_last;
  logic [7:0]    char_n_byte;

  // Nibble to uppercase ASCII hex digit.
  function automatic logic [7:0] hex_char(input logic [3:0] n);
    if (n <= 4'd9) return 8'h30 + {4'h0, n};
    else           return 8'h37 + {4'h0, n};
  endfunction

  // Nibble select by character index, most significant nibble first.
  function automatic logic [3:0] nibble_sel(input logic [15:0] w, input logic [1:0] idx);
    case (idx)
      2'd0:    return w[15:12];
      2'd1:    return w[11:8];
      2'd2:    return w[7:4];
      default: return w[3:0];
    endcase
  endfunction

  assign baud_last = (baud == CW'(CLKS_PER_BIT - 1));
  assign in_ready  = (state == IDLE) && !rst;
  assign busy      = (state != IDLE);

  // Next-state, counter and line-level logic.
  always_comb begin
    state_n  = state;
    baud_n   = baud;
    bit_n    = bit_idx;
    char_n   = char_idx;
    shadow_n = shadow;
    tx_n     = 1'b1;

    case (state)
      IDLE: begin
        if (in_valid && in_ready) begin
          state_n  = START;
          shadow_n = in_data;
          char_n   = 2'd0;
          bit_n    = 3'd0;
          baud_n   = '0;
        end
      end
      START: begin
        if (baud_last) begin
          baud_n  = '0;
          bit_n   = 3'd0;
          state_n = DATA;
        end else begin
          baud_n = baud + CW'(1);
        end
      end
      DATA: begin
        if (baud_last) begin
          baud_n = '0;
          if (bit_idx == 3'd7) begin
            state_n = STOP;
          end else begin
            bit_n = bit_idx + 3'd1;
          end
        end else begin
          baud_n = baud + CW'(1);
        end
      end
      STOP: begin
        if (baud_last) begin
          baud_n = '0;
          if (char_idx == 2'd3) begin
            state_n = IDLE;
          end else begin
            char_n  = char_idx + 2'd1;
            state_n = START;
          end
        end else begin
          baud_n = baud + CW'(1);
        end
      end
      default: state_n = IDLE;
    endcase

    // Line level is derived from the next state so tx can be registered
    // and still change on the same edge as the state.
    char_n_byte = hex_char(nibble_sel(shadow_n, char_n));
    case (state_n)
      START:   tx_n = 1'b0;
      DATA:    tx_n = char_n_byte[bit_n];
      default: tx_n = 1'b1;
    endcase
  end

  // State, counters, shadow word and registered serial line.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      baud     <= '0;
      bit_idx  <= '0;
      char_idx <= '0;
      shadow   <= '0;
      tx       <= 1'b1;
    end else begin
      state    <= state_n;
      baud     <= baud_n;
      bit_idx  <= bit_n;
      char_idx <= char_n;
      shadow   <= shadow_n;
      tx       <= tx_n;
    end
  end

endmodule

// File: tb/tb_uart_hex_tx.sv
// Directed bench for uart_hex_tx with a short bit period; decodes the line
// from per-clock samples and compares against hand-computed ASCII bytes.
module tb_uart_hex_tx;

  localparam int unsigned CPB       = 4;
  localparam int unsigned WORD_CLKS = 40 * CPB;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic        tx;
  logic        busy;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  logic        smp [0:WORD_CLKS-1];

  uart_hex_tx #(.CLKS_PER_BIT(CPB)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .tx       (tx),
    .busy     (busy)
  );

  // 100 MHz-style free-running clock.
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a word; returns just after the accepting edge.
  task automatic start_word(input logic [15:0] w, input bit hold);
    int unsigned n;
    n = 0;
    while (!in_ready && n < 200) begin
      tick();
      n++;
    end
    check("ready_before_send", {31'd0, in_ready}, 32'd1);
    in_data  = w;
    in_valid = 1'b1;
    tick();
    if (!hold) in_valid = 1'b0;
    check("start_low", {31'd0, tx}, 32'd0);
    check("busy_on_accept", {31'd0, busy}, 32'd1);
  endtask

  // Capture one full word starting at the first start-bit clock, decode it,
  // then confirm the block is back in IDLE exactly 40 bit periods later.
  task automatic recv_word(input string tag, input logic [31:0] exp_bytes);
    int unsigned busy_low, unstable, framing, base;
    logic [7:0]  b [4];
    logic [31:0] got;
    busy_low = 0;
    unstable = 0;
    framing  = 0;
    for (int i = 0; i < WORD_CLKS; i++) begin
      if (i != 0) tick();
      smp[i] = tx;
      if (!busy) busy_low++;
    end
    for (int c = 0; c < 4; c++) begin
      for (int s = 0; s < 10; s++) begin
        base = c * 10 * CPB + s * CPB;
        for (int k = 1; k < CPB; k++)
          if (smp[base + k] !== smp[base]) unstable++;
        if (s == 0 && smp[base] !== 1'b0) framing++;
        if (s == 9 && smp[base] !== 1'b1) framing++;
        if (s >= 1 && s <= 8) b[c][s - 1] = smp[base + CPB / 2];
      end
    end
    got = {b[0], b[1], b[2], b[3]};
    $display("rx line: (%c%c%c%c)", b[0], b[1], b[2], b[3]);
    check({tag, "_bytes"}, got, exp_bytes);
    check({tag, "_bit_stable"}, unstable, 32'd0);
    check({tag, "_framing"}, framing, 32'd0);
    check({tag, "_busy_held"}, busy_low, 32'd0);
    tick();
    check({tag, "_end_ready"}, {31'd0, in_ready}, 32'd1);
    check({tag, "_end_busy"}, {31'd0, busy}, 32'd0);
    check({tag, "_end_tx"}, {31'd0, tx}, 32'd1);
  endtask

  initial begin
    logic        slots [11];
    int unsigned bad, lows, busys;
    slots = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};

    rst      = 1'b1;
    in_valid = 1'b0;
    in_data  = '0;
    repeat (3) tick();
    check("rst_tx", {31'd0, tx}, 32'd1);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_ready_low", {31'd0, in_ready}, 32'd0);
    rst = 1'b0;
    #1;
    check("post_rst_ready", {31'd0, in_ready}, 32'd1);

    // Single word and hex letters.
    start_word(16'h0003, 1'b0);
    recv_word("w0003", 32'h30303033);
    start_word(16'hBEEF, 1'b0);
    recv_word("wBEEF", 32'h42454546);
    start_word(16'hA9F0, 1'b0);
    recv_word("wA9F0", 32'h41394630);

    // Clock-exact line pattern: start, '0' = 0x30 LSB first, stop, next start.
    start_word(16'h0001, 1'b0);
    recv_word("w0001", 32'h30303031);
    bad = 0;
    for (int i = 0; i < 11 * CPB; i++)
      if (smp[i] !== slots[i / CPB]) bad++;
    check("bit_timing_pattern", bad, 32'd0);

    // Back-to-back with in_valid held; data changes while busy are ignored.
    start_word(16'h1234, 1'b1);
    in_data = 16'h5678;
    recv_word("b2b_1234", 32'h31323334);
    tick();
    check("b2b_second_start", {31'd0, tx}, 32'd0);
    check("b2b_second_busy", {31'd0, busy}, 32'd1);
    in_valid = 1'b0;
    in_data  = 16'hFFFF;
    recv_word("b2b_5678", 32'h35363738);

    // Reset during DATA of character index 2.
    start_word(16'h1234, 1'b0);
    repeat (90) tick();
    check("mid_busy_before_rst", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    check("mid_rst_tx", {31'd0, tx}, 32'd1);
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    check("mid_rst_ready", {31'd0, in_ready}, 32'd1);
    start_word(16'h00FF, 1'b0);
    recv_word("w00FF", 32'h30304646);

    // Reset has priority over a simultaneous valid.
    rst      = 1'b1;
    in_valid = 1'b1;
    in_data  = 16'h4321;
    #1;
    check("prio_ready_low", {31'd0, in_ready}, 32'd0);
    tick();
    rst      = 1'b0;
    in_valid = 1'b0;
    lows  = 0;
    busys = 0;
    for (int i = 0; i < 10 * CPB + 2; i++) begin
      if (tx !== 1'b1) lows++;
      if (busy !== 1'b0) busys++;
      tick();
    end
    check("prio_no_start", lows, 32'd0);
    check("prio_not_busy", busys, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
